// File: rtl/fc_obuf_sched.sv
// fc_obuf_sched: drains the CIM output buffers of a fully connected layer.
// For each output neuron it reads one word from every vertical tile of the
// neuron's tile column. It sums those words into an unsigned accumulator and
// presents the sum to the next layer through a valid/ready handshake.
//
// Handshake semantics: o_valid is raised with o_data once a sum is complete.
// Both stay unchanged until a cycle in which o_valid and i_next_ready are high
// together. That cycle is the transfer, and the block advances on the
// following edge. o_valid never drops without a transfer.
module fc_obuf_sched #(
    parameter int XBAR_SIZE      = 512,
    parameter int DATA_SIZE      = 8,
    parameter int OUTPUT_NEURONS = 10,
    parameter int V_CIM_TILES    = 8,
    parameter int H_CIM_TILES    = (OUTPUT_NEURONS * DATA_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
    parameter int OBUF_DATA_SIZE = 2 * DATA_SIZE + $clog2(XBAR_SIZE),
    localparam int ELEMS         = XBAR_SIZE / DATA_SIZE,
    localparam int ACC_SIZE      = OBUF_DATA_SIZE + $clog2(V_CIM_TILES),
    localparam int ADDR_W        = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                i_start,
    input  logic                                                i_cim_ready,
    output logic                                                o_ready,
    output logic [ADDR_W-1:0]                                   o_cim_rd_addr,
    input  logic [V_CIM_TILES*H_CIM_TILES*OBUF_DATA_SIZE-1:0]   i_data,
    output logic                                                o_valid,
    input  logic                                                i_next_ready,
    output logic [ACC_SIZE-1:0]                                 o_data,
    output logic                                                o_done,
    output logic [2:0]                                          o_dbg_state
);

    localparam int E_W = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;
    localparam int V_W = (V_CIM_TILES > 1) ? $clog2(V_CIM_TILES) : 1;
    localparam int H_W = (H_CIM_TILES > 1) ? $clog2(H_CIM_TILES) : 1;

    localparam logic [E_W-1:0]    E_LAST = E_W'(OUTPUT_NEURONS - 1);
    localparam logic [V_W-1:0]    V_LAST = V_W'(V_CIM_TILES - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(ELEMS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CIM = 3'd1,
        FETCH    = 3'd2,
        ACC      = 3'd3,
        OUT      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [E_W-1:0]          e;
    logic [V_W-1:0]          v;
    logic [H_W-1:0]          h;
    logic [ACC_SIZE-1:0]     acc;
    logic [ACC_SIZE-1:0]     acc_sum;
    logic [OBUF_DATA_SIZE-1:0] tile_word;
    int                      tile_idx;

    // State register; reset aborts any pass in flight and returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode. FETCH covers the one-cycle buffer read latency.
    // ACC spends one cycle per vertical tile.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = i_cim_ready ? FETCH : WAIT_CIM;
                end
            end
            WAIT_CIM: begin
                if (i_cim_ready) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = ACC;
            end
            ACC: begin
                if (v == V_LAST) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (i_next_ready) begin
                    state_nxt = (e == E_LAST) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select the word of tile (v,h) and form the running sum (zero-extended).
    always_comb begin
        tile_idx  = int'(v) * H_CIM_TILES + int'(h);
        tile_word = i_data[tile_idx*OBUF_DATA_SIZE +: OBUF_DATA_SIZE];
        acc_sum   = acc + ACC_SIZE'(tile_word);
    end

    // Datapath: element/tile/address bookkeeping, accumulation and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e             <= '0;
            v             <= '0;
            h             <= '0;
            acc           <= '0;
            o_data        <= '0;
            o_cim_rd_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        e             <= '0;
                        h             <= '0;
                        o_cim_rd_addr <= '0;
                    end
                end
                FETCH: begin
                    acc <= '0;
                    v   <= '0;
                end
                ACC: begin
                    acc <= acc_sum;
                    if (v == V_LAST) begin
                        v      <= '0;
                        o_data <= acc_sum;
                    end else begin
                        v <= v + V_W'(1);
                    end
                end
                OUT: begin
                    // Advance to the next neuron. Wrapping the address moves to the next tile column.
                    if (i_next_ready && (e != E_LAST)) begin
                        e <= e + E_W'(1);
                        if (o_cim_rd_addr == A_LAST) begin
                            o_cim_rd_addr <= '0;
                            h             <= h + H_W'(1);
                        end else begin
                            o_cim_rd_addr <= o_cim_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decode directly from the state, so reset affects them immediately.
    always_comb begin
        o_ready     = (state == IDLE);
        o_valid     = (state == OUT);
        o_done      = (state == DONE);
        o_dbg_state = state;
    end

endmodule

// File: doc/fc_obuf_sched.md
FC_OBUF_SCHED -- requirements
Module: fc_obuf_sched

Interface
REQ-001 SHALL have parameter XBAR_SIZE, default 512, meaning CIM crossbar dimension.
REQ-002 SHALL have parameter DATA_SIZE, default 8, meaning weight width in bits.
REQ-003 SHALL have parameter OUTPUT_NEURONS, default 10, meaning outputs produced per layer pass.
REQ-004 SHALL have parameter V_CIM_TILES, default 8, meaning vertical tiles whose partial sums add per output.
REQ-005 SHALL have parameter H_CIM_TILES, default ceil(OUTPUT_NEURONS*DATA_SIZE/XBAR_SIZE) = 1, meaning horizontal tile count.
REQ-006 SHALL have parameter OBUF_DATA_SIZE, default 2*DATA_SIZE+clog2(XBAR_SIZE) = 25, meaning per-tile output buffer word width.
REQ-007 SHALL derive ELEMS = XBAR_SIZE/DATA_SIZE (64), meaning outputs per tile, and ACC_SIZE = OBUF_DATA_SIZE+clog2(V_CIM_TILES) (28).
REQ-008 clk  in  1  sole clock; all state on rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 i_start  in  1  single-cycle request to drain CIM output buffers.
REQ-011 i_cim_ready  in  1  CIM tiles finished; buffer contents valid.
REQ-012 o_ready  out  1  block idle, accepts i_start.
REQ-013 o_cim_rd_addr  out  clog2(ELEMS)  output buffer read address, common to all tiles.
REQ-014 i_data  in  V_CIM_TILES*H_CIM_TILES*OBUF_DATA_SIZE  flattened buffer words; tile (v,h) at bit offset (v*H_CIM_TILES+h)*OBUF_DATA_SIZE.
REQ-015 o_valid  out  1  o_data holds a completed output.
REQ-016 i_next_ready  in  1  next layer accepts o_data.
REQ-017 o_data  out  ACC_SIZE  summed output neuron value.
REQ-018 o_done  out  1  one-cycle pulse after last output accepted.

Function
REQ-019 SHALL implement states IDLE, WAIT_CIM, FETCH, ACC, OUT, DONE.
REQ-020 IDLE: o_ready=1; i_start with i_cim_ready -> FETCH; i_start without i_cim_ready -> WAIT_CIM; element index e cleared to 0 on either.
REQ-021 WAIT_CIM: o_ready=0; i_cim_ready=1 -> FETCH.
REQ-022 o_cim_rd_addr SHALL be registered = e mod ELEMS; tile column h = e div ELEMS; both updated on entry to FETCH.
REQ-023 FETCH: exactly one cycle (buffer read latency); accumulator and tile index v cleared to 0; -> ACC.
REQ-024 ACC: exactly V_CIM_TILES cycles; each cycle acc += zero-extended word of tile (v,h), v increments; after v = V_CIM_TILES-1 -> OUT.
REQ-025 Sum SHALL be unsigned, ACC_SIZE wide, never overflow.
REQ-026 OUT: o_valid=1, o_data=acc held stable until i_next_ready=1 on same cycle as o_valid (handshake).
REQ-027 On handshake: if e = OUTPUT_NEURONS-1 -> DONE, else e+1 -> FETCH.
REQ-028 DONE: o_done=1 one cycle, o_valid=0 -> IDLE.
REQ-029 Throughput with i_next_ready held high: V_CIM_TILES+2 cycles per output; o_done N*(V_CIM_TILES+2)+1 cycles after entering FETCH-first.
REQ-030 i_start outside IDLE SHALL be ignored; i_cim_ready deassertion after leaving WAIT_CIM SHALL be ignored.
REQ-031 o_valid SHALL never deassert without handshake; o_data SHALL not change while o_valid=1.
REQ-032 Crossing tile boundary (e mod ELEMS wraps to 0) SHALL increment h and reset address to 0.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE, o_ready=1, o_valid=0, o_done=0, o_cim_rd_addr=0, o_data=0, e=v=h=0, acc=0.
REQ-034 Reset mid-operation SHALL abort the pass with no o_done; next i_start restarts at e=0.

Verification
REQ-035 Defaults, tile v words = v+1 all addresses, i_start+i_cim_ready, next ready high -> 10 outputs each 36, o_done at cycle 101.
REQ-036 i_start with i_cim_ready=0 for 5 cycles -> WAIT_CIM, o_ready=0, o_cim_rd_addr=0 no valid until ready rises.
REQ-037 i_next_ready low 4 cycles during first OUT -> o_valid held, o_data=36 stable, then e=1, o_cim_rd_addr=1.
REQ-038 All words 2^25-1, V=8 -> o_data = 8*(2^25-1) = 268435448, no overflow.
REQ-039 OUTPUT_NEURONS=130, H_CIM_TILES=3 -> e=64 reads h=1 addr 0; e=128 reads h=2 addr 0; 130 outputs then o_done.
REQ-040 rst=0 during ACC of e=3 -> outputs at reset values immediately; new i_start produces e=0 first.
